sync_fifo_param: RTL

Parametrised single-clock FIFO, successor to the fixed 8-bit / 9-entry buffer. Generalises data width and depth, with depth not restricted to powers of two. Adds an occupancy output, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a selectable first-word-fall-through read mode. Used as the standard elastic buffer between byte and word streaming stages in the same clock domain.

---
 rtl/sync_fifo_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sync_fifo_param                                              |
// | Brief   : Single-clock FIFO, any depth, level flags, sticky errors,    |
// |           registered or first-word-fall-through read port.             |
// | Revision: 1.0 - initial parametrised release                           |
// +------------------------------------------------------------------------+
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 9,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [CW-1:0]     count,
  output logic              f_full,
  output logic              f_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
  localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_ae_level = CW'(AE_LEVEL);

  if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
      AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_param_check
    $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign f_full       = (r_count == c_depth);
  assign f_empty      = (r_count == '0);
  assign almost_full  = (r_count >= c_af_level);
  assign almost_empty = (r_count <= c_ae_level);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Acceptance uses the pre-edge flags, so a full FIFO rejects a write even when a read frees a slot.
  assign w_wr_acc = w_en & ~f_full;
  assign w_rd_acc = r_en & ~f_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set beats clear when both happen in one cycle.
      if (w_en & f_full)     r_overflow <= 1'b1;
      else if (clr_err)      r_overflow <= 1'b0;
      if (r_en & f_empty)    r_underflow <= 1'b1;
      else if (clr_err)      r_underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = r_mem[r_rptr];
    assign rd_valid = ~f_empty;
  end else begin : g_reg_read
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data_out <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_data_out <= r_mem[r_rptr];
      end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
  end

endmodule
`default_nettype wire
